ls_cnt_error_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel latch-sample error counter. Each channel compares a delayed sample of its CREST_IN line against its RPG_IN reference and counts mismatch events. A measurement-window FSM starts, stops and freezes all counters together, and a registered readout mux exposes one channel's count at a time. The block sits between the DUT capture pins and the host register interface in the 22nm test FPGA.

---
 rtl/ls_cnt_error_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_ls_cnt_error_mc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_cnt_error_mc.sv
// ---------------------------------------------------------------------------
// ls_cnt_error_mc -- multi-channel latch-sample error counter.
//
// Each channel registers its CREST_IN bit into a sample chain, picks the
// stage chosen by the latched delay select and compares it with RPG_IN.
// A shared measurement-window FSM (IDLE/FILL/RUN/DONE) gates counting for
// all channels. One channel's count is exposed through a registered mux.
//
// Optional feature macro: LS_CNT_FIRST_ERR_EN
//   defined   : per-channel capture of CYC_CNT at the first error of the
//               window, read out on FIRST_ERR_CYC alongside ERR_CNT_RD.
//   undefined : FIRST_ERR_CYC is tied to all-ones.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   CLR               synchronous clear of counters, forces IDLE
//   START / STOP      window start pulse / early stop pulse
//   WIN_LEN           RUN length in cycles, 0 = unlimited
//   DLY_SEL           extra sample delay, latched on START
//   INV_MODE          1: error on equality, 0: error on difference
//   CREST_IN, RPG_IN  per-channel sample / reference bits
//   RD_SEL            readout channel select (>= NCH reads 0)
//   COMP_OUT          combinational per-channel error flags
//   ERR_CNT_RD        registered count of channel RD_SEL
//   CYC_CNT           RUN cycles elapsed in current/last window
//   BUSY / DONE       window in progress / window finished
//   SAT               sticky: a channel counter hit all-ones this window
//   FIRST_ERR_CYC     first-error cycle of channel RD_SEL (see macro)
// ---------------------------------------------------------------------------

// Per-channel lane: sample chain, compare and saturating error counter.
module ls_cnt_error_lane #(
  parameter int CW    = 32,
  parameter int DLY_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             crest_i,
  input  logic             rpg_i,
  input  logic             inv_i,
  input  logic [DLY_W-1:0] dly_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             comp_o,
  output logic [CW-1:0]    cnt_o,
  output logic             hit_o
);
  localparam int NST = 1 << DLY_W;

  logic [NST-1:0] stage_q, stage_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cmp;

  always_comb begin
    stage_d = {stage_q[NST-2:0], crest_i};
    cmp     = stage_q[dly_i];
    comp_o  = inv_i ? ~(cmp ^ rpg_i) : (cmp ^ rpg_i);
    cnt_d   = cnt_q;
    if (clr_i)                                cnt_d = '0;
    else if (en_i && comp_o && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  // Flag the cycle a counter lands on all-ones; the top keeps it sticky.
  assign hit_o = &cnt_d;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module ls_cnt_error_mc #(
  parameter int NCH   = 4,
  parameter int CW    = 32,
  parameter int DLY_W = 2,
  parameter int SEL_W = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             START,
  input  logic             STOP,
  input  logic [31:0]      WIN_LEN,
  input  logic [DLY_W-1:0] DLY_SEL,
  input  logic             INV_MODE,
  input  logic [NCH-1:0]   CREST_IN,
  input  logic [NCH-1:0]   RPG_IN,
  input  logic [SEL_W-1:0] RD_SEL,
  output logic [NCH-1:0]   COMP_OUT,
  output logic [CW-1:0]    ERR_CNT_RD,
  output logic [31:0]      CYC_CNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             SAT,
  output logic [31:0]      FIRST_ERR_CYC
);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [DLY_W-1:0]     dly_q, dly_d, fill_q, fill_d;
  logic [31:0]          cyc_q, cyc_d;
  logic                 sat_q, sat_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]        rd_q, rd_d;
  logic                 start_acc, lane_clr, lane_en, win_end;
  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0]       hit;

  // START is only honoured outside a window; CLR overrides everything.
  assign start_acc = START && (state_q == S_IDLE || state_q == S_DONE);
  assign lane_clr  = CLR || start_acc;
  assign lane_en   = !CLR && (state_q == S_RUN);
  assign win_end   = (WIN_LEN != '0) && (cyc_q == WIN_LEN - 32'd1);

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      ls_cnt_error_lane #(.CW(CW), .DLY_W(DLY_W)) u_lane (
        .clk    (CLK),
        .rst_n  (RST_N),
        .crest_i(CREST_IN[g]),
        .rpg_i  (RPG_IN[g]),
        .inv_i  (INV_MODE),
        .dly_i  (dly_q),
        .clr_i  (lane_clr),
        .en_i   (lane_en),
        .comp_o (COMP_OUT[g]),
        .cnt_o  (cnt[g]),
        .hit_o  (hit[g])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    fill_d  = fill_q;
    cyc_d   = cyc_q;
    if (CLR) begin
      state_d = S_IDLE;
      cyc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (START) begin
          state_d = S_FILL;
          dly_d   = DLY_SEL;
          fill_d  = '0;
          cyc_d   = '0;
        end
        // Priming: dly_q+1 cycles so the selected stage holds post-START data.
        S_FILL: begin
          if (STOP)                 state_d = S_DONE;
          else if (fill_q == dly_q) state_d = S_RUN;
          else                      fill_d  = fill_q + 1'b1;
        end
        // The cycle that ends the window is itself counted.
        S_RUN: begin
          if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
          if (STOP || win_end) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    sat_d  = lane_clr ? 1'b0 : (sat_q | (|hit));
    busy_d = (state_d == S_FILL) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    rd_d   = '0;
    for (int i = 0; i < NCH; i++)
      if (RD_SEL == SEL_W'(i)) rd_d = cnt[i];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      fill_q  <= '0;
      cyc_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      fill_q  <= fill_d;
      cyc_q   <= cyc_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
    end
  end

  assign ERR_CNT_RD = rd_q;
  assign CYC_CNT    = cyc_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign SAT        = sat_q;

`ifdef LS_CNT_FIRST_ERR_EN
  // All-ones marks "no error yet this window".
  logic [NCH-1:0][31:0] first_q, first_d;
  logic [31:0]          frd_q, frd_d;

  always_comb begin
    first_d = first_q;
    frd_d   = '1;
    for (int i = 0; i < NCH; i++) begin
      if (lane_clr)
        first_d[i] = '1;
      else if (lane_en && COMP_OUT[i] && first_q[i] == '1)
        first_d[i] = cyc_q;
      if (RD_SEL == SEL_W'(i)) frd_d = first_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_q <= '1;
      frd_q   <= '1;
    end else begin
      first_q <= first_d;
      frd_q   <= frd_d;
    end
  end

  assign FIRST_ERR_CYC = frd_q;
`else
  assign FIRST_ERR_CYC = '1;
`endif
endmodule

// File: tb/tb_ls_cnt_error_mc.sv
// Self-checking bench for ls_cnt_error_mc: directed windows with literal
// expectations, then randomized control/data against a behavioural model.
module tb_ls_cnt_error_mc;
  localparam int NCH = 4, CW = 4, DLY_W = 2, SEL_W = 3;
  localparam int NST = 1 << DLY_W;
  localparam int MAXC = (1 << CW) - 1;

  logic CLK = 0, RST_N = 0, CLR = 0, START = 0, STOP = 0, INV_MODE = 0;
  logic [31:0]      WIN_LEN = 0;
  logic [DLY_W-1:0] DLY_SEL = 0;
  logic [NCH-1:0]   CREST_IN = 0, RPG_IN = 0;
  logic [SEL_W-1:0] RD_SEL = 0;
  logic [NCH-1:0]   COMP_OUT;
  logic [CW-1:0]    ERR_CNT_RD;
  logic [31:0]      CYC_CNT, FIRST_ERR_CYC;
  logic             BUSY, DONE, SAT;

  ls_cnt_error_mc #(.NCH(NCH), .CW(CW), .DLY_W(DLY_W), .SEL_W(SEL_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .START(START), .STOP(STOP),
    .WIN_LEN(WIN_LEN), .DLY_SEL(DLY_SEL), .INV_MODE(INV_MODE),
    .CREST_IN(CREST_IN), .RPG_IN(RPG_IN), .RD_SEL(RD_SEL),
    .COMP_OUT(COMP_OUT), .ERR_CNT_RD(ERR_CNT_RD), .CYC_CNT(CYC_CNT),
    .BUSY(BUSY), .DONE(DONE), .SAT(SAT), .FIRST_ERR_CYC(FIRST_ERR_CYC)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist[k] = CREST_IN as seen k+1 edges ago.
  logic [NCH-1:0] m_hist [NST];
  int     m_dly, m_fill, m_cnt [NCH];
  bit     m_busy, m_done;
  longint m_cyc, m_first [NCH], m_rd, m_frd;

  function automatic logic [NCH-1:0] exp_comp();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++)
      r[i] = INV_MODE ? (m_hist[m_dly][i] == RPG_IN[i]) : (m_hist[m_dly][i] != RPG_IN[i]);
    return r;
  endfunction

  function automatic bit exp_sat();
    bit s = 0;
    for (int i = 0; i < NCH; i++) if (m_cnt[i] == MAXC) s = 1;
    return s;
  endfunction

  function automatic logic [31:0] exp_first();
`ifdef LS_CNT_FIRST_ERR_EN
    return (m_frd < 0) ? 32'hFFFF_FFFF : m_frd[31:0];
`else
    return 32'hFFFF_FFFF;
`endif
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NST; k++) m_hist[k] = '0;
      m_dly = 0; m_fill = 0; m_busy = 0; m_done = 0; m_cyc = 0;
      for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_first[i] = -1; end
      m_rd = 0; m_frd = -1;
    end else begin
      logic [NCH-1:0] c;
      bit last;
      c = exp_comp();
      if (RD_SEL < NCH) begin m_rd = m_cnt[RD_SEL]; m_frd = m_first[RD_SEL]; end
      else begin m_rd = 0; m_frd = -1; end
      if (CLR) begin
        m_busy = 0; m_done = 0; m_cyc = 0;
        for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_first[i] = -1; end
      end else if (!m_busy && START) begin
        m_busy = 1; m_done = 0; m_dly = DLY_SEL; m_fill = int'(DLY_SEL) + 1; m_cyc = 0;
        for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_first[i] = -1; end
      end else if (m_busy && m_fill > 0) begin
        if (STOP) begin m_busy = 0; m_done = 1; end
        else m_fill--;
      end else if (m_busy) begin
        for (int i = 0; i < NCH; i++)
          if (c[i]) begin
            if (m_first[i] < 0) m_first[i] = m_cyc;
            if (m_cnt[i] < MAXC) m_cnt[i]++;
          end
        last = STOP || (WIN_LEN != 0 && m_cyc == longint'(WIN_LEN) - 1);
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        if (last) begin m_busy = 0; m_done = 1; end
      end
      for (int k = NST - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = CREST_IN;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("comp_out", COMP_OUT, exp_comp());
    chk("err_cnt_rd", ERR_CNT_RD, m_rd);
    chk("cyc_cnt", CYC_CNT, m_cyc[31:0]);
    chk("busy", BUSY, m_busy);
    chk("done", DONE, m_done);
    chk("sat", SAT, exp_sat());
    chk("first_err_cyc", FIRST_ERR_CYC, exp_first());
  end

  // ---------------- stimulus ----------------
  logic [NCH-1:0] pat [8192];
  int gcyc = 16, lat = 0;
  logic [NCH-1:0] flip = '0;

  // Advance one cycle; RPG is the pattern, CREST leads it by lat+1 cycles.
  task automatic step();
    @(posedge CLK); #1;
    gcyc++;
    CREST_IN = pat[gcyc % 8192] ^ flip;
    RPG_IN   = pat[(gcyc - 1 - lat) % 8192];
  endtask

  task automatic pulse_start(input int dly, input int win, input bit inv);
    DLY_SEL = DLY_W'(dly); WIN_LEN = win; INV_MODE = inv; START = 1;
    step();
    START = 0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (DONE !== 1'b1 && n < max) begin step(); n++; end
  endtask

  task automatic rd(input int sel, output int v);
    RD_SEL = SEL_W'(sel);
    step();
    v = int'(ERR_CNT_RD);
  endtask

  initial begin
    int n, v, sum;
    for (int i = 0; i < 8192; i++) pat[i] = NCH'($urandom_range(0, 15));
    step(); step();
    // reset values
    chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0); chk("rst_cyc", CYC_CNT, 0);
    chk("rst_rd", ERR_CNT_RD, 0); chk("rst_sat", SAT, 0);
    chk("rst_first", FIRST_ERR_CYC, 32'hFFFF_FFFF);
    RST_N = 1;
    step(); step();

    // aligned data, WIN_LEN=100: no errors, 100 RUN cycles
    lat = 0;
    pulse_start(0, 100, 0);
    chk("busy_after_start", BUSY, 1);
    wait_done(300, n);
    chk("win100_done_latency", n, 101);
    chk("win100_cyc", CYC_CNT, 100);
    sum = 0;
    for (int i = 0; i < NCH; i++) begin rd(i, v); sum += v; end
    chk("win100_errs", sum, 0);

    // channel 2 inverted for 7 RUN cycles
    flip = 4'b0100;
    pulse_start(0, 20, 0);
    repeat (6) step();
    flip = '0;
    wait_done(100, n);
    rd(2, v); chk("ch2_cnt", v, 7);
    rd(0, v); chk("ch0_cnt", v, 0);
    rd(1, v); chk("ch1_cnt", v, 0);
    rd(3, v); chk("ch3_cnt", v, 0);
    rd(5, v); chk("sel_oob", v, 0);

    // DLY_SEL=3 aligned to 4-cycle latency
    lat = 3;
    pulse_start(3, 10, 0);
    wait_done(100, n);
    chk("dly3_done_latency", n, 14);
    sum = 0;
    for (int i = 0; i < NCH; i++) begin rd(i, v); sum += v; end
    chk("dly3_errs", sum, 0);
    pulse_start(0, 10, 0);
    wait_done(100, n);
    sum = 0;
    for (int i = 0; i < NCH; i++) begin rd(i, v); sum += v; end
    chk("misaligned_nonzero", sum > 0, 1);

    // saturation at CW=4
    lat = 0;
    pulse_start(0, 20, 1);
    wait_done(100, n);
    rd(1, v); chk("sat_cnt", v, 15);
    chk("sat_flag", SAT, 1);
    pulse_start(0, 5, 0);
    chk("sat_cleared", SAT, 0);
    rd(1, v); chk("cnt_cleared", v, 0);
    wait_done(100, n);

    // unlimited window, STOP during 37th RUN cycle
    pulse_start(0, 0, 0);
    repeat (37) step();
    STOP = 1; step(); STOP = 0;
    chk("stop_done", DONE, 1);
    chk("stop_cyc", CYC_CNT, 37);

`ifdef LS_CNT_FIRST_ERR_EN
    pulse_start(0, 20, 0);
    repeat (4) step();
    flip = 4'b0010; step(); flip = '0;
    wait_done(100, n);
    RD_SEL = 1; step(); chk("first_ch1", FIRST_ERR_CYC, 5);
    RD_SEL = 0; step(); chk("first_ch0", FIRST_ERR_CYC, 32'hFFFF_FFFF);
`else
    chk("first_tied", FIRST_ERR_CYC, 32'hFFFF_FFFF);
`endif

    // reset mid-RUN
    pulse_start(0, 0, 1);
    repeat (8) step();
    RST_N = 0; #1;
    chk("midrst_busy", BUSY, 0); chk("midrst_done", DONE, 0); chk("midrst_cyc", CYC_CNT, 0);
    chk("midrst_sat", SAT, 0); chk("midrst_rd", ERR_CNT_RD, 0);
    chk("midrst_first", FIRST_ERR_CYC, 32'hFFFF_FFFF);
    step(); RST_N = 1; step();

    // CLR together with START stays IDLE
    CLR = 1; START = 1; step(); CLR = 0; START = 0;
    chk("clr_start_busy", BUSY, 0);
    step();
    chk("clr_start_busy2", BUSY, 0);

    // randomized phase
    for (int t = 0; t < 3000; t++) begin
      START = ($urandom_range(0, 19) == 0);
      STOP  = ($urandom_range(0, 39) == 0);
      CLR   = ($urandom_range(0, 149) == 0);
      if (START) begin
        WIN_LEN = $urandom_range(0, 40);
        DLY_SEL = DLY_W'($urandom_range(0, 3));
      end
      RD_SEL = SEL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) INV_MODE = ~INV_MODE;
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 3);
      flip = ($urandom_range(0, 5) == 0) ? NCH'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 799) == 0) begin
        RST_N = 0; step(); RST_N = 1;
      end else begin
        step();
      end
    end
    START = 0; STOP = 0; CLR = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
